// File: rtl/qm_pkg.sv
// Shared definitions for the teller dispatcher slice of the bank queue.
// Contents:
//   state_t      - dispatcher FSM states (IDLE, CALL)
//   TID_W        - width of a teller identifier and of the teller count
//   MAX_TELLERS  - largest number of stations whose count fits in TID_W bits
package qm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALL = 1'b1
  } state_t;

  localparam int TID_W       = 2;
  localparam int MAX_TELLERS = 3;

endpackage

// File: rtl/teller_dispatcher_if.sv
// Bundle of every signal exchanged between the teller dispatcher and the
// rest of the bank: teller stations, queue manager and front photocell.
// Modports:
//   slave  - the dispatcher side (consumes station/queue status, drives calls)
//   master - the environment side (stations, queue manager, photocell)
// Signals:
//   teller_on    station i is open (level)
//   teller_done  station i finished its customer (one-cycle pulse)
//   q_empty      queue manager reports an empty queue
//   front_pc     front photocell, active-low, idle high
//   call_valid   a call is being displayed
//   call_id      teller being called
//   dispatch     one-cycle pulse, customer handed to disp_id
//   disp_id      teller receiving the customer
//   call_timeout one-cycle pulse, the call expired as a no-show
//   busy         station i is serving a customer
//   tcount       registered count of open stations
interface teller_dispatcher_if
  import qm_pkg::*;
#(
  parameter int NUM_TELLERS = 3
);

  logic [NUM_TELLERS-1:0] teller_on;
  logic [NUM_TELLERS-1:0] teller_done;
  logic                   q_empty;
  logic                   front_pc;
  logic                   call_valid;
  logic [TID_W-1:0]       call_id;
  logic                   dispatch;
  logic [TID_W-1:0]       disp_id;
  logic                   call_timeout;
  logic [NUM_TELLERS-1:0] busy;
  logic [TID_W-1:0]       tcount;

  modport slave (
    input  teller_on, teller_done, q_empty, front_pc,
    output call_valid, call_id, dispatch, disp_id, call_timeout, busy, tcount
  );

  modport master (
    output teller_on, teller_done, q_empty, front_pc,
    input  call_valid, call_id, dispatch, disp_id, call_timeout, busy, tcount
  );

endinterface

// File: rtl/teller_dispatcher_rr_pick.sv
// Round-robin selector for the next teller to call.
// Starting just after the teller served most recently, it returns the first
// available station, wrapping around modulo NUM_TELLERS. Purely combinational.
// Ports:
//   avail_i   station i is open and not busy
//   rr_ptr_i  teller that last received (or timed out on) a call
//   found_o   at least one station is available
//   id_o      chosen station, meaningful only when found_o is high
module rr_pick
  import qm_pkg::*;
#(
  parameter int NUM_TELLERS = 3
) (
  input  logic [NUM_TELLERS-1:0] avail_i,
  input  logic [TID_W-1:0]       rr_ptr_i,
  output logic                   found_o,
  output logic [TID_W-1:0]       id_o
);

  logic [TID_W-1:0] idx;

  // Walk the candidates from the farthest one back to rr_ptr+1 so that the
  // last hit written is the closest station after the pointer; the pointer's
  // own station comes last in priority, since it has just been served.
  always_comb begin
    found_o = 1'b0;
    id_o    = '0;
    idx     = '0;
    for (int k = NUM_TELLERS; k >= 1; k--) begin
      idx = TID_W'((int'(rr_ptr_i) + k) % NUM_TELLERS);
      if (avail_i[idx]) begin
        found_o = 1'b1;
        id_o    = idx;
      end
    end
  end

endmodule

// File: rtl/teller_dispatcher.sv
// Teller dispatcher for the single-bank queue.
// Calls the front customer to one free teller in round-robin order, confirms
// the hand-off on a falling edge of the front photocell, gives up after
// CALL_TIMEOUT cycles, tracks which tellers are busy and publishes the
// registered open-teller count used by the queue manager.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  dispatcher side of teller_dispatcher_if (all status and call signals)
module teller_dispatcher
  import qm_pkg::*;
#(
  parameter int NUM_TELLERS  = 3,
  parameter int CALL_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  teller_dispatcher_if.slave  bus
);

  localparam int CNT_W = (CALL_TIMEOUT > 1) ? $clog2(CALL_TIMEOUT) : 1;

  state_t                 state_q, state_d;
  logic [TID_W-1:0]       rrPtr_q, rrPtr_d;
  logic [TID_W-1:0]       callId_q, callId_d;
  logic [TID_W-1:0]       dispId_q, dispId_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   dispatch_q, dispatch_d;
  logic                   timeout_q, timeout_d;
  logic [NUM_TELLERS-1:0] busy_q, busy_d;
  logic [TID_W-1:0]       tcount_q, tcount_d;
  logic                   frontPc_q;

  logic [NUM_TELLERS-1:0] avail;
  logic [NUM_TELLERS-1:0] setBusy;
  logic                   fall;
  logic                   pickFound;
  logic [TID_W-1:0]       pickId;

  assign avail = bus.teller_on & ~busy_q;
  assign fall  = frontPc_q & ~bus.front_pc;

  rr_pick #(
    .NUM_TELLERS (NUM_TELLERS)
  ) uPick (
    .avail_i  (avail),
    .rr_ptr_i (rrPtr_q),
    .found_o  (pickFound),
    .id_o     (pickId)
  );

  // All state, including the photocell history, is cleared synchronously.
  // The pointer resets to the last station so teller 0 is the first one called.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rrPtr_q    <= TID_W'(NUM_TELLERS - 1);
      callId_q   <= '0;
      dispId_q   <= '0;
      cnt_q      <= '0;
      dispatch_q <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= '0;
      tcount_q   <= '0;
      frontPc_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      rrPtr_q    <= rrPtr_d;
      callId_q   <= callId_d;
      dispId_q   <= dispId_d;
      cnt_q      <= cnt_d;
      dispatch_q <= dispatch_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
      tcount_q   <= tcount_d;
      frontPc_q  <= bus.front_pc;
    end
  end

  // Call sequencing. A call is aborted silently when the called teller closes
  // or the queue empties; otherwise a photocell fall hands the customer over,
  // and that is checked before the timeout so a late arrival still counts.
  always_comb begin
    state_d    = state_q;
    rrPtr_d    = rrPtr_q;
    callId_d   = callId_q;
    dispId_d   = dispId_q;
    cnt_d      = cnt_q;
    dispatch_d = 1'b0;
    timeout_d  = 1'b0;
    setBusy    = '0;
    unique case (state_q)
      IDLE: begin
        if (pickFound && !bus.q_empty) begin
          callId_d = pickId;
          cnt_d    = '0;
          state_d  = CALL;
        end
      end
      CALL: begin
        if (!bus.teller_on[callId_q] || bus.q_empty) begin
          state_d = IDLE;
        end else if (fall) begin
          dispatch_d        = 1'b1;
          dispId_d          = callId_q;
          setBusy[callId_q] = 1'b1;
          rrPtr_d           = callId_q;
          state_d           = IDLE;
        end else if (cnt_q == CNT_W'(CALL_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          rrPtr_d   = callId_q;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Busy bits clear when the teller finishes or closes and are set only by a
  // dispatch; a called teller is never busy, so set and clear never collide.
  always_comb begin
    busy_d   = (busy_q & ~bus.teller_done & bus.teller_on) | setBusy;
    tcount_d = TID_W'($countones(bus.teller_on));
  end

  assign bus.call_valid   = (state_q == CALL);
  assign bus.call_id      = callId_q;
  assign bus.dispatch     = dispatch_q;
  assign bus.disp_id      = dispId_q;
  assign bus.call_timeout = timeout_q;
  assign bus.busy         = busy_q;
  assign bus.tcount       = tcount_q;

endmodule

// File: tb/tb_teller_dispatcher.sv
// Self-checking bench for teller_dispatcher (3 tellers, 15-cycle call timeout).
// Expected call/dispatch/timeout events are queued as stimulus is applied and
// matched in order by a monitor; directed checks cover timing and busy state.
module tb_teller_dispatcher;

  localparam int EV_CALL = 1;
  localparam int EV_DISP = 2;
  localparam int EV_TMO  = 3;

  typedef struct {
    int         kind;
    logic [1:0] id;
  } ev_t;

  logic clk;
  logic rst;
  int   totalChecks = 0;
  int   badChecks   = 0;
  ev_t  expQ[$];
  logic prevValid = 1'b0;

  teller_dispatcher_if #(.NUM_TELLERS(3)) bus ();

  teller_dispatcher #(
    .NUM_TELLERS  (3),
    .CALL_TIMEOUT (15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    if (obs !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Set every environment input, then advance the given number of cycles.
  task automatic applyStimulus(input logic [2:0] on, input logic [2:0] done,
                               input logic qe, input logic pc, input int cycles);
    bus.teller_on   = on;
    bus.teller_done = done;
    bus.q_empty     = qe;
    bus.front_pc    = pc;
    step(cycles);
  endtask

  task automatic pushExp(input int kind, input logic [1:0] id);
    ev_t e;
    e.kind = kind;
    e.id   = id;
    expQ.push_back(e);
  endtask

  task automatic waitCall(input int maxCycles);
    int n;
    n = 0;
    while (!bus.call_valid && n < maxCycles) begin
      step(1);
      n++;
    end
    checkOutput("callWait", 32'(bus.call_valid), 1);
  endtask

  // Serve the pending call: photocell high one cycle, then low for two.
  task automatic serveCall(input logic [1:0] id);
    waitCall(20);
    step(1);
    bus.front_pc = 1'b0;
    step(1);
    checkOutput("dispPulse", 32'(bus.dispatch), 1);
    checkOutput("dispId", 32'(bus.disp_id), 32'(id));
    checkOutput("dispNoTmo", 32'(bus.call_timeout), 0);
    step(1);
    checkOutput("dispSingle", 32'(bus.dispatch), 0);
    bus.front_pc = 1'b1;
  endtask

  task automatic scoreEvent(input int kind, input logic [1:0] id);
    ev_t e;
    if (expQ.size() == 0) begin
      checkOutput("sbUnexpected", 32'(kind), 0);
    end else begin
      e = expQ.pop_front();
      checkOutput("sbKind", 32'(kind), 32'(e.kind));
      checkOutput("sbId", 32'(id), 32'(e.id));
    end
  endtask

  // Monitor: turn DUT outputs into events and match them against the queue.
  always @(posedge clk) begin
    #2;
    if (bus.call_valid && !prevValid) scoreEvent(EV_CALL, bus.call_id);
    if (bus.dispatch) scoreEvent(EV_DISP, bus.disp_id);
    if (bus.call_timeout) scoreEvent(EV_TMO, 2'd0);
    prevValid = bus.call_valid;
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int len;
    rst = 1'b1;
    applyStimulus(3'b000, 3'b000, 1'b1, 1'b1, 3);
    checkOutput("rstValid", 32'(bus.call_valid), 0);
    checkOutput("rstDisp", 32'(bus.dispatch), 0);
    checkOutput("rstTmo", 32'(bus.call_timeout), 0);
    checkOutput("rstBusy", 32'(bus.busy), 0);
    checkOutput("rstTcount", 32'(bus.tcount), 0);
    checkOutput("rstCallId", 32'(bus.call_id), 0);
    checkOutput("rstDispId", 32'(bus.disp_id), 0);

    // First call goes to teller 0 one cycle after the request appears.
    rst = 1'b0;
    pushExp(EV_CALL, 2'd0);
    applyStimulus(3'b111, 3'b000, 1'b0, 1'b1, 1);
    checkOutput("firstValid", 32'(bus.call_valid), 1);
    checkOutput("firstId", 32'(bus.call_id), 0);
    checkOutput("tcount3", 32'(bus.tcount), 3);

    // Serve tellers 0, 1, 2 in round-robin order.
    pushExp(EV_DISP, 2'd0);
    pushExp(EV_CALL, 2'd1);
    serveCall(2'd0);
    checkOutput("busy001", 32'(bus.busy), 32'b001);
    pushExp(EV_DISP, 2'd1);
    pushExp(EV_CALL, 2'd2);
    serveCall(2'd1);
    pushExp(EV_DISP, 2'd2);
    serveCall(2'd2);
    checkOutput("busy111", 32'(bus.busy), 32'b111);
    step(3);
    checkOutput("allBusyIdle", 32'(bus.call_valid), 0);

    // Free tellers 0 and 1; call 0 times out, then teller 1 is tried.
    pushExp(EV_CALL, 2'd0);
    pushExp(EV_TMO, 2'd0);
    pushExp(EV_CALL, 2'd1);
    applyStimulus(3'b111, 3'b011, 1'b0, 1'b1, 1);
    applyStimulus(3'b111, 3'b000, 1'b0, 1'b1, 0);
    waitCall(5);
    len = 0;
    while (bus.call_valid && len < 40) begin
      len++;
      step(1);
    end
    checkOutput("callLen", 32'(len), 15);
    checkOutput("tmoPulse", 32'(bus.call_timeout), 1);
    checkOutput("tmoNoDisp", 32'(bus.dispatch), 0);
    checkOutput("tmoBusy", 32'(bus.busy), 32'b100);
    waitCall(5);
    checkOutput("afterTmoId", 32'(bus.call_id), 1);

    // Queue empties mid-call: silent abort.
    step(1);
    applyStimulus(3'b111, 3'b000, 1'b1, 1'b1, 1);
    checkOutput("qeAbortValid", 32'(bus.call_valid), 0);
    checkOutput("qeAbortDisp", 32'(bus.dispatch), 0);
    checkOutput("qeAbortTmo", 32'(bus.call_timeout), 0);
    step(2);
    checkOutput("qeStayIdle", 32'(bus.call_valid), 0);

    // Called teller closes mid-call: silent abort, teller 0 called next.
    pushExp(EV_CALL, 2'd1);
    applyStimulus(3'b111, 3'b000, 1'b0, 1'b1, 0);
    waitCall(5);
    step(1);
    pushExp(EV_CALL, 2'd0);
    applyStimulus(3'b101, 3'b000, 1'b0, 1'b1, 1);
    checkOutput("offAbortValid", 32'(bus.call_valid), 0);
    checkOutput("offAbortDisp", 32'(bus.dispatch), 0);
    checkOutput("offAbortTmo", 32'(bus.call_timeout), 0);
    checkOutput("offBusy", 32'(bus.busy), 32'b100);
    checkOutput("tcount2", 32'(bus.tcount), 2);
    pushExp(EV_DISP, 2'd0);
    serveCall(2'd0);
    checkOutput("busy101", 32'(bus.busy), 32'b101);

    // Fill all tellers, free teller 1, and land the fall on the last cycle.
    pushExp(EV_CALL, 2'd1);
    pushExp(EV_DISP, 2'd1);
    applyStimulus(3'b111, 3'b000, 1'b0, 1'b1, 0);
    serveCall(2'd1);
    step(3);
    checkOutput("fullIdle", 32'(bus.call_valid), 0);
    checkOutput("fullBusy", 32'(bus.busy), 32'b111);
    pushExp(EV_CALL, 2'd1);
    pushExp(EV_DISP, 2'd1);
    applyStimulus(3'b111, 3'b010, 1'b0, 1'b1, 1);
    applyStimulus(3'b111, 3'b000, 1'b0, 1'b1, 0);
    waitCall(5);
    checkOutput("doneCallId", 32'(bus.call_id), 1);
    step(14);
    checkOutput("lastCycleValid", 32'(bus.call_valid), 1);
    bus.front_pc = 1'b0;
    step(1);
    checkOutput("raceDisp", 32'(bus.dispatch), 1);
    checkOutput("raceDispId", 32'(bus.disp_id), 1);
    checkOutput("raceNoTmo", 32'(bus.call_timeout), 0);
    step(1);
    checkOutput("raceNoTmoLate", 32'(bus.call_timeout), 0);
    bus.front_pc = 1'b1;

    // Reset in the middle of a call to teller 2.
    pushExp(EV_CALL, 2'd2);
    applyStimulus(3'b111, 3'b100, 1'b0, 1'b1, 1);
    applyStimulus(3'b111, 3'b000, 1'b0, 1'b1, 0);
    waitCall(5);
    step(1);
    rst = 1'b1;
    step(1);
    checkOutput("midRstValid", 32'(bus.call_valid), 0);
    checkOutput("midRstDisp", 32'(bus.dispatch), 0);
    checkOutput("midRstTmo", 32'(bus.call_timeout), 0);
    checkOutput("midRstBusy", 32'(bus.busy), 0);
    checkOutput("midRstTcount", 32'(bus.tcount), 0);
    checkOutput("midRstCallId", 32'(bus.call_id), 0);
    checkOutput("midRstDispId", 32'(bus.disp_id), 0);
    pushExp(EV_CALL, 2'd0);
    rst = 1'b0;
    step(1);
    checkOutput("postRstValid", 32'(bus.call_valid), 1);
    checkOutput("postRstId", 32'(bus.call_id), 0);
    checkOutput("postRstTcount", 32'(bus.tcount), 3);

    applyStimulus(3'b111, 3'b000, 1'b1, 1'b1, 3);
    checkOutput("sbDrain", 32'(expQ.size()), 0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
